// File: rtl/div_sqrt_2_pkg.sv
// Shared constants and helpers for the div_sqrt_2 datapath and its scheduler.
package div_sqrt_2_pkg;

  localparam int LAT_DEFAULT = 2;

  function automatic int width(input int n);
    return 1 << n;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  // Tag layout: {valid, id}, valid in the MSB.
  function automatic int tag_w(input int id_w);
    return id_w + 1;
  endfunction

endpackage

// File: rtl/div_sqrt_2_sched_rr_arbiter.sv
// R-input round-robin arbiter; the pointer moves past the winner on every grant.
module div_sqrt_2_sched_rr_arbiter #(
  parameter int R    = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [R-1:0]    req,
  output logic [R-1:0]    grant,
  output logic [ID_W-1:0] win_id
);

  logic [ID_W-1:0] ptr;
  logic            found;
  logic [ID_W-1:0] idx_b;
  int              idx;

  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    idx    = 0;
    idx_b  = '0;
    for (int k = 0; k < R; k++) begin
      idx = int'(ptr) + k;
      if (idx >= R) idx = idx - R;
      idx_b = ID_W'(idx);
      if (!found && en && req[idx_b]) begin
        found        = 1'b1;
        grant[idx_b] = 1'b1;
        win_id       = idx_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      ptr <= '0;
    else if (found)
      ptr <= (win_id == ID_W'(R - 1)) ? '0 : win_id + 1'b1;
  end

endmodule

// File: rtl/div_sqrt_2_sched.sv
// Round-robin scheduler sharing one external div_sqrt_2 datapath among R requesters.
// Optional per-requester grant counters: define DIV_SQRT_2_SCHED_STATS_EN.
module div_sqrt_2_sched
  import div_sqrt_2_pkg::*;
#(
  parameter int N       = 4,
  parameter int R       = 4,
  parameter int LAT     = LAT_DEFAULT,
  parameter int MAX_OUT = 3,
  localparam int W      = width(N),
  localparam int ID_W   = clog2(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic [R-1:0]    req_valid,
  input  logic [R*W-1:0]  req_data,
  output logic [R-1:0]    req_ready,
  output logic [W-1:0]    dp_in,
  input  logic [W-1:0]    dp_out,
  output logic            rsp_valid,
  output logic [ID_W-1:0] rsp_id,
  output logic [W-1:0]    rsp_data,
  output logic            busy,
  output logic [R*16-1:0] stat_grants
);

  localparam int TAG_W = tag_w(ID_W);
  localparam int CNT_W = clog2(MAX_OUT + 1);

  logic [TAG_W-1:0] tag [LAT:0];
  logic [CNT_W-1:0] in_flight;
  logic [ID_W-1:0]  win_id;
  logic [W-1:0]     sel_data;
  logic             can_issue;
  logic             acc;

  assign rsp_valid = tag[LAT][TAG_W-1];
  assign rsp_id    = tag[LAT][ID_W-1:0];
  assign rsp_data  = dp_out;
  assign busy      = (in_flight != '0);

  // A response retiring this cycle frees its slot, so the pipe can stay full.
  assign can_issue = ((in_flight < CNT_W'(MAX_OUT)) || rsp_valid) && !flush && rst;
  assign acc       = |req_ready;

  div_sqrt_2_sched_rr_arbiter #(.R(R), .ID_W(ID_W)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (can_issue),
    .req    (req_valid),
    .grant  (req_ready),
    .win_id (win_id)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < R; i++)
      if (req_ready[i]) sel_data = req_data[i*W +: W];
  end

  always_ff @(posedge clk) begin
    if (!rst)
      dp_in <= '0;
    else if (acc)
      dp_in <= sel_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      for (int k = 0; k <= LAT; k++) tag[k] <= '0;
    end else begin
      tag[0] <= acc ? {1'b1, win_id} : '0;
      for (int k = 1; k <= LAT; k++) tag[k] <= tag[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || flush)
      in_flight <= '0;
    else if (acc && !rsp_valid)
      in_flight <= in_flight + 1'b1;
    else if (!acc && rsp_valid)
      in_flight <= in_flight - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      assert (in_flight <= CNT_W'(MAX_OUT));
      assert (!(rsp_valid && in_flight == '0));
    end
  end

`ifdef DIV_SQRT_2_SCHED_STATS_EN
  for (genvar i = 0; i < R; i++) begin : g_stat
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
      if (!rst)
        cnt <= '0;
      else if (req_ready[i] && cnt != 16'hFFFF)
        cnt <= cnt + 16'd1;
    end
    assign stat_grants[i*16 +: 16] = cnt;
  end
`else
  assign stat_grants = '0;
`endif

endmodule
